// File: rtl/xalu_seq.sv
// -----------------------------------------------------------------------------
// xalu_seq -- multiply/divide sequencer feeding the architectural HI/LO pair.
//
// One operation is launched per accepted `start`. The 64-bit result is
// computed in the launch cycle and parked in pend_hi/pend_lo. It is then held
// back while `busy` is high for a fixed, operation-dependent latency, and
// finally committed to HI/LO in a single edge. mthi/mtlo writes are serviced
// only while idle.
//
// Ports
//   clk       in   1   rising-edge clock
//   reset     in   1   asynchronous, active-high; clears all state
//   start     in   1   launch pulse, qualified by a legal `op`
//   op        in   3   1=mult 2=multu 3=div 4=divu 5=madd, others ignored
//   A         in  32   rs operand (multiplicand / dividend)
//   B         in  32   rt operand (multiplier / divisor)
//   hilo_we   in   1   mthi/mtlo write strobe (idle only)
//   hilo_sel  in   1   0 = write LO, 1 = write HI
//   WD        in  32   mthi/mtlo write data
//   busy      out  1   operation in flight
//   HI        out 32   architectural HI
//   LO        out 32   architectural LO
// -----------------------------------------------------------------------------
module xalu_seq #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        hilo_we,
   input  logic        hilo_sel,
   input  logic [31:0] WD,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   typedef enum logic [2:0] {
      OP_MULT  = 3'd1,
      OP_MULTU = 3'd2,
      OP_DIV   = 3'd3,
      OP_DIVU  = 3'd4,
      OP_MADD  = 3'd5
   } op_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   state_e      state, state_next;
   logic [3:0]  cnt, cnt_next;
   logic [31:0] pend_hi, pend_hi_next;
   logic [31:0] pend_lo, pend_lo_next;
   logic        pend_wr, pend_wr_next;   // 0 when a divide-by-zero must leave HI/LO alone
   logic [31:0] hi_q, hi_next;
   logic [31:0] lo_q, lo_next;

   // ---------------------------------------------------------------------------
   // Datapath: every result is formed combinationally from the launch-cycle
   // operands; only the selected one is captured.
   // ---------------------------------------------------------------------------
   logic        op_legal;
   logic [63:0] prod_s, prod_u, madd_sum;
   logic        a_neg, b_neg, signed_div;
   logic [31:0] abs_a, abs_b, div_n, div_d, div_d_safe;
   logic [31:0] quot_u, rem_u, quot, rem;

   assign op_legal = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) ||
                     (op == OP_DIVU) || (op == OP_MADD);

   // Explicit sign/zero extension keeps the 64-bit products independent of
   // expression-signedness rules.
   assign prod_s   = {{32{A[31]}}, A} * {{32{B[31]}}, B};
   assign prod_u   = {32'd0, A} * {32'd0, B};
   assign madd_sum = {hi_q, lo_q} + prod_s;

   // Signed division runs on magnitudes so that -2^31 and truncation toward
   // zero behave identically in every tool; signs are restored afterwards.
   assign signed_div = (op == OP_DIV);
   assign a_neg      = A[31];
   assign b_neg      = B[31];
   assign abs_a      = a_neg ? -A : A;
   assign abs_b      = b_neg ? -B : B;
   assign div_n      = signed_div ? abs_a : A;
   assign div_d      = signed_div ? abs_b : B;
   // A zero divisor never commits; the substitute only keeps the divider
   // away from an undefined result.
   assign div_d_safe = (div_d == 32'd0) ? 32'd1 : div_d;
   assign quot_u     = div_n / div_d_safe;
   assign rem_u      = div_n % div_d_safe;
   assign quot       = (signed_div && (a_neg ^ b_neg)) ? -quot_u : quot_u;
   assign rem        = (signed_div && a_neg) ? -rem_u : rem_u;

   // ---------------------------------------------------------------------------
   // Next-state / next-data logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default before any branch so no path leaves
      // it unassigned, which would infer a latch.
      state_next   = state;
      cnt_next     = cnt;
      pend_hi_next = pend_hi;
      pend_lo_next = pend_lo;
      pend_wr_next = pend_wr;
      hi_next      = hi_q;
      lo_next      = lo_q;

      case (state)
         IDLE: begin
            // start takes priority: a coincident mthi/mtlo write is dropped
            // and madd sees the pre-write HI/LO.
            if (start) begin
               if (op_legal) begin
                  state_next   = RUN;
                  pend_wr_next = 1'b1;
                  case (op)
                     OP_MULT: begin
                        {pend_hi_next, pend_lo_next} = prod_s;
                        cnt_next = 4'(MULT_CYCLES);
                     end
                     OP_MULTU: begin
                        {pend_hi_next, pend_lo_next} = prod_u;
                        cnt_next = 4'(MULT_CYCLES);
                     end
                     OP_MADD: begin
                        {pend_hi_next, pend_lo_next} = madd_sum;
                        cnt_next = 4'(MULT_CYCLES);
                     end
                     default: begin   // OP_DIV, OP_DIVU
                        pend_hi_next = rem;
                        pend_lo_next = quot;
                        pend_wr_next = (B != 32'd0);
                        cnt_next     = 4'(DIV_CYCLES);
                     end
                  endcase
               end
            end else if (hilo_we) begin
               if (hilo_sel) hi_next = WD;
               else          lo_next = WD;
            end
         end

         RUN: begin
            // start and hilo_we are deliberately not looked at here.
            cnt_next = cnt - 4'd1;
            if (cnt == 4'd1) begin
               state_next = IDLE;
               if (pend_wr) begin
                  hi_next = pend_hi;
                  lo_next = pend_lo;
               end
            end
         end

         default: state_next = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   // NOTE: reset is asynchronous so an abort mid-operation clears the pending
   // result and HI/LO immediately, without waiting for a clock edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         pend_hi <= 32'd0;
         pend_lo <= 32'd0;
         pend_wr <= 1'b0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else begin
         // NOTE: non-blocking assignments make every register update from
         // the pre-edge values, independent of statement order.
         state   <= state_next;
         cnt     <= cnt_next;
         pend_hi <= pend_hi_next;
         pend_lo <= pend_lo_next;
         pend_wr <= pend_wr_next;
         hi_q    <= hi_next;
         lo_q    <= lo_next;
      end
   end

   assign busy = (cnt != 4'd0);
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

// File: tb/tb_xalu_seq.sv
// -----------------------------------------------------------------------------
// tb_xalu_seq -- directed vectors for xalu_seq with hand-computed results.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_xalu_seq;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] A;
   logic [31:0] B;
   logic        hilo_we;
   logic        hilo_sel;
   logic [31:0] WD;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;

   int vectors     = 0;
   int miscompares = 0;

   xalu_seq #(
      .MULT_CYCLES(5),
      .DIV_CYCLES (10)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .op      (op),
      .A       (A),
      .B       (B),
      .hilo_we (hilo_we),
      .hilo_sel(hilo_sel),
      .WD      (WD),
      .busy    (busy),
      .HI      (HI),
      .LO      (LO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_hilo(input logic sel, input logic [31:0] data);
      hilo_we  = 1'b1;
      hilo_sel = sel;
      WD       = data;
      tick();
      hilo_we  = 1'b0;
   endtask

   // Launch one operation, then count busy cycles (bounded). When disrupt is
   // set, a div start and an mtlo write are held during busy cycles 2 and 3.
   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int n_exp, input bit disrupt);
      int n;
      op    = o;
      A     = a;
      B     = b;
      start = 1'b1;
      check({tag, "_busy_launch"}, 64'(busy), 64'd0);
      tick();
      start = 1'b0;
      op    = 3'd0;
      n     = 0;
      while (busy && n < 40) begin
         n++;
         if (disrupt && n == 2) begin
            start    = 1'b1;
            op       = 3'd3;
            A        = 32'd100;
            B        = 32'd7;
            hilo_we  = 1'b1;
            hilo_sel = 1'b0;
            WD       = 32'h0000DEAD;
         end
         if (disrupt && n == 4) begin
            start   = 1'b0;
            op      = 3'd0;
            hilo_we = 1'b0;
         end
         tick();
      end
      start   = 1'b0;
      hilo_we = 1'b0;
      check({tag, "_busy_len"}, 64'(n), 64'(n_exp));
   endtask

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      op       = 3'd0;
      A        = 32'd0;
      B        = 32'd0;
      hilo_we  = 1'b0;
      hilo_sel = 1'b0;
      WD       = 32'd0;
      #12;
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_hilo", {HI, LO}, 64'd0);
      tick();
      reset = 1'b0;
      tick();

      // mult -3 * 5 = -15
      run_op("mult", 3'd1, 32'hFFFFFFFD, 32'd5, 5, 1'b0);
      check("mult_hilo", {HI, LO}, 64'hFFFFFFFF_FFFFFFF1);

      // multu 0xFFFFFFFD * 5, launched back-to-back in the busy-fall cycle
      run_op("multu", 3'd2, 32'hFFFFFFFD, 32'd5, 5, 1'b0);
      check("multu_hilo", {HI, LO}, 64'h00000004_FFFFFFF1);

      // div -7 / 2 -> q=-3, r=-1
      run_op("div", 3'd3, 32'hFFFFFFF9, 32'd2, 10, 1'b0);
      check("div_hilo", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);

      // divu 7 / 2 -> q=3, r=1
      run_op("divu", 3'd4, 32'd7, 32'd2, 10, 1'b0);
      check("divu_hilo", {HI, LO}, 64'h00000001_00000003);

      // mthi/mtlo visible the next cycle, then divide by zero leaves them alone
      write_hilo(1'b1, 32'h11);
      check("mthi", 64'(HI), 64'h11);
      write_hilo(1'b0, 32'h22);
      check("mtlo", 64'(LO), 64'h22);
      run_op("div0", 3'd3, 32'd9, 32'd0, 10, 1'b0);
      check("div0_hilo", {HI, LO}, 64'h00000011_00000022);

      // madd carry from LO into HI
      write_hilo(1'b1, 32'h0);
      write_hilo(1'b0, 32'hFFFFFFFF);
      run_op("madd", 3'd5, 32'd1, 32'd1, 5, 1'b0);
      check("madd_hilo", {HI, LO}, 64'h00000001_00000000);

      // start wins over a coincident mtlo: madd uses {1,0}, write of 0x55 dropped
      hilo_we  = 1'b1;
      hilo_sel = 1'b0;
      WD       = 32'h55;
      run_op("madd_we", 3'd5, 32'd2, 32'd3, 5, 1'b0);
      check("madd_we_hilo", {HI, LO}, 64'h00000001_00000006);

      // illegal op launches nothing
      op    = 3'd7;
      start = 1'b1;
      tick();
      start = 1'b0;
      op    = 3'd0;
      check("illegal_busy", 64'(busy), 64'd0);
      tick();
      check("illegal_busy2", 64'(busy), 64'd0);
      check("illegal_hilo", {HI, LO}, 64'h00000001_00000006);

      // start and hilo_we while busy are ignored
      run_op("ignore", 3'd1, 32'd3, 32'd4, 5, 1'b1);
      check("ignore_hilo", {HI, LO}, 64'h00000000_0000000C);
      tick();
      check("ignore_idle", 64'(busy), 64'd0);

      // reset in busy cycle 4 of a divide: immediate clear, no late commit
      op    = 3'd3;
      A     = 32'd100;
      B     = 32'd7;
      start = 1'b1;
      tick();
      start = 1'b0;
      op    = 3'd0;
      repeat (3) tick();
      check("rst_mid_busy_pre", 64'(busy), 64'd1);
      reset = 1'b1;
      #1;
      check("rst_mid_busy", 64'(busy), 64'd0);
      check("rst_mid_hilo", {HI, LO}, 64'd0);
      tick();
      reset = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         check("rst_after_hilo", {HI, LO}, 64'd0);
         check("rst_after_busy", 64'(busy), 64'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
